// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the intersection signal blocks.
//   state_t   : scheduler state codes (also driven out as the debug phase)
//   RED/YELLOW/GREEN : one-hot signal head encodings {red, yellow, green}
//   PHASE_W   : width of the state / phase code
package traffic_pkg;

   localparam int PHASE_W = 3;

   typedef enum logic [PHASE_W-1:0] {
      ALL_RED = 3'd0,
      NS_G    = 3'd1,
      NS_Y    = 3'd2,
      EW_G    = 3'd3,
      EW_Y    = 3'd4,
      WALK    = 3'd5
   } state_t;

   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] YELLOW = 3'b010;
   localparam logic [2:0] GREEN  = 3'b001;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk down to a one-cycle tick every TICK_DIV cycles.
//   clk   : clock
//   rst   : synchronous active-high reset, counter to 0
//   clear : restart the count at 0 on the next cycle (phase realignment)
//   tick  : high on the cycle the count reaches TICK_DIV-1
module tick_prescaler #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = $clog2(TICK_DIV - 1) + 1;

   logic [CNT_W-1:0] cnt;

   assign tick = (cnt == CNT_W'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || clear)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: demand-actuated two-way intersection scheduler with
// an exclusive pedestrian phase.
//   clk, rst  : clock, synchronous active-high reset
//   ns_req    : NS vehicle detector (level, sampled on ticks)
//   ew_req    : EW vehicle detector (level, sampled on ticks)
//   ped_req   : pedestrian button (latched every cycle outside WALK)
//   NS_light  : NS head, one-hot {red, yellow, green}
//   EW_light  : EW head, same encoding
//   walk      : walk lamp, high only in WALK
//   phase     : current state code
module traffic_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int TICK_DIV  = 100_000_000,
   parameter int MIN_GREEN = 4,
   parameter int MAX_GREEN = 10,
   parameter int YELLOW_T  = 2,
   parameter int ALL_RED_T = 1,
   parameter int WALK_T    = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ns_req,
   input  logic               ew_req,
   input  logic               ped_req,
   output logic [2:0]         NS_light,
   output logic [2:0]         EW_light,
   output logic               walk,
   output logic [PHASE_W-1:0] phase
);

   localparam int TMAX_A = (YELLOW_T > ALL_RED_T) ? YELLOW_T : ALL_RED_T;
   localparam int TMAX   = (TMAX_A > WALK_T) ? TMAX_A : WALK_T;
   localparam int T_W    = $clog2(TMAX) + 1;
   localparam int EL_W   = $clog2(MAX_GREEN) + 1;

   state_t          state, state_next;
   logic            state_chg;
   logic            tick;
   logic [T_W-1:0]  tmr, t_inc;
   logic [EL_W-1:0] elapsed, e_inc;
   logic            ped_pending;
   logic            last_ns;   // 1: NS had the most recent green, 0: EW

   assign state_chg = (state_next != state);

   // Every state change realigns the tick grid so each timed state lasts
   // exactly N*TICK_DIV cycles.
   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clk   (clk),
      .rst   (rst),
      .clear (state_chg),
      .tick  (tick)
   );

   // Tick counts including the current tick; used for the decision made on it.
   assign t_inc = (tmr == T_W'(TMAX)) ? tmr : tmr + 1'b1;
   assign e_inc = (elapsed == EL_W'(MAX_GREEN)) ? elapsed : elapsed + 1'b1;

   always_ff @(posedge clk) begin
      if (rst)
         state <= ALL_RED;
      else
         state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst || state_chg) begin
         tmr     <= '0;
         elapsed <= '0;
      end else if (tick) begin
         tmr     <= t_inc;
         elapsed <= e_inc;
      end
   end

   // Entry into WALK wins over a same-cycle press so the request is consumed.
   always_ff @(posedge clk) begin
      if (rst)
         ped_pending <= 1'b0;
      else if (state_next == WALK && state != WALK)
         ped_pending <= 1'b0;
      else if (state != WALK && ped_req)
         ped_pending <= 1'b1;
   end

   // Reset to EW-served so NS gets the first green.
   always_ff @(posedge clk) begin
      if (rst)
         last_ns <= 1'b0;
      else if (state_chg && state_next == NS_G)
         last_ns <= 1'b1;
      else if (state_chg && state_next == EW_G)
         last_ns <= 1'b0;
   end

   always_comb begin
      state_next = state;
      case (state)
         NS_G:
            if (tick && (ew_req || ped_pending) &&
                ((e_inc >= EL_W'(MIN_GREEN) && !ns_req) || e_inc == EL_W'(MAX_GREEN)))
               state_next = NS_Y;
         EW_G:
            if (tick && (ns_req || ped_pending) &&
                ((e_inc >= EL_W'(MIN_GREEN) && !ew_req) || e_inc == EL_W'(MAX_GREEN)))
               state_next = EW_Y;
         NS_Y, EW_Y:
            if (tick && t_inc == T_W'(YELLOW_T))
               state_next = ALL_RED;
         ALL_RED:
            if (tick && t_inc == T_W'(ALL_RED_T))
               state_next = ped_pending ? WALK : (last_ns ? EW_G : NS_G);
         WALK:
            if (tick && t_inc == T_W'(WALK_T))
               state_next = last_ns ? EW_G : NS_G;
         default:
            state_next = ALL_RED;
      endcase
   end

   always_comb begin
      NS_light = RED;
      EW_light = RED;
      walk     = 1'b0;
      case (state)
         NS_G:    NS_light = GREEN;
         NS_Y:    NS_light = YELLOW;
         EW_G:    EW_light = GREEN;
         EW_Y:    EW_light = YELLOW;
         WALK:    walk     = 1'b1;
         default: ;
      endcase
   end

   assign phase = state;

endmodule
